// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//
// Multi-cycle adder/subtractor. One DIGIT-wide ripple stage is reused for
// N = WIDTH/DIGIT clock cycles, least-significant digit first, with the
// inter-digit carry kept in a register. Operands are captured on the input
// handshake; the result is presented under an output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request
//   in_ready   high while idle (operands can be accepted)
//   a, b       WIDTH-bit operands
//   c_in       carry-in (add) or borrow-in (subtract)
//   sub        0: a + b + c_in, 1: a - b - c_in
//   out_valid  result available, held until out_ready
//   out_ready  consumer accepts the result
//   sum        result modulo 2^WIDTH
//   c_out      add: carry out; subtract: 1 = no borrow
//   ovf        two's-complement signed overflow
// -----------------------------------------------------------------------------
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg;
   logic             carry_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_eff_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             c_out_reg;
   logic             ovf_reg;
   logic             out_valid_reg;

   logic             accept;
   logic             last_digit;
   logic             release_result;
   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic [DIGIT-1:0] d_sum;
   logic             d_carry;
   logic [WIDTH-1:0] acc_next;

   // ---------------------------------------------------------------------------
   // Control FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM: next state and control strobes
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      in_ready       = 1'b0;
      accept         = 1'b0;
      last_digit     = 1'b0;
      release_result = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (cnt_reg == LAST) begin
               last_digit = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            // out_valid is always high in DONE, so out_ready alone completes
            // the result handshake.
            if (out_ready) begin
               release_result = 1'b1;
               state_next     = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Digit datapath: one DIGIT-wide ripple add selected by the counter
   // ---------------------------------------------------------------------------
   always_comb begin
      a_dig              = a_reg[int'(cnt_reg)*DIGIT +: DIGIT];
      b_dig              = b_eff_reg[int'(cnt_reg)*DIGIT +: DIGIT];
      {d_carry, d_sum}   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_reg};
      acc_next           = acc_reg;
      acc_next[int'(cnt_reg)*DIGIT +: DIGIT] = d_sum;
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg       <= '0;
         carry_reg     <= 1'b0;
         a_reg         <= '0;
         b_eff_reg     <= '0;
         acc_reg       <= '0;
         sum_reg       <= '0;
         c_out_reg     <= 1'b0;
         ovf_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         if (accept) begin
            a_reg     <= a;
            // Subtraction is A + ~B + ~borrow_in: B is inverted once here and
            // the carry register is seeded with c_in XOR sub.
            b_eff_reg <= b ^ {WIDTH{sub}};
            carry_reg <= c_in ^ sub;
            cnt_reg   <= '0;
         end

         if (state_reg == RUN) begin
            // Partial digits build up in acc_reg so the visible sum only
            // changes when a complete result is ready.
            acc_reg   <= acc_next;
            carry_reg <= d_carry;
            if (!last_digit) begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end

         if (last_digit) begin
            sum_reg       <= acc_next;
            c_out_reg     <= d_carry;
            // Signed overflow: operands share a sign bit and the result's
            // sign differs (equivalent to carry-in XOR carry-out of the MSB).
            ovf_reg       <= (a_dig[DIGIT-1] == b_dig[DIGIT-1]) &&
                             (d_sum[DIGIT-1] != a_dig[DIGIT-1]);
            out_valid_reg <= 1'b1;
         end

         if (release_result) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign sum       = sum_reg;
   assign c_out     = c_out_reg;
   assign ovf       = ovf_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
//
// Three instances of digit_serial_adder (16/4, 8/8, 8/1) share the operand
// pins and out_ready; each has its own in_valid. Expected results come from
// an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_digit_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  in_valid = 3'b000;
   logic        out_ready = 1'b0;
   logic [15:0] a = 16'h0;
   logic [15:0] b = 16'h0;
   logic        c_in = 1'b0;
   logic        sub = 1'b0;

   logic        rdy0, rdy1, rdy2;
   logic        ov0, ov1, ov2;
   logic        co0, co1, co2;
   logic        f0, f1, f2;
   logic [15:0] sum0;
   logic [7:0]  sum1, sum2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16_d4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy0),
      .a(a), .b(b), .c_in(c_in), .sub(sub),
      .out_valid(ov0), .out_ready(out_ready), .sum(sum0), .c_out(co0), .ovf(f0)
   );

   digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_w8_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy1),
      .a(a[7:0]), .b(b[7:0]), .c_in(c_in), .sub(sub),
      .out_valid(ov1), .out_ready(out_ready), .sum(sum1), .c_out(co1), .ovf(f1)
   );

   digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(rdy2),
      .a(a[7:0]), .b(b[7:0]), .c_in(c_in), .sub(sub),
      .out_valid(ov2), .out_ready(out_ready), .sum(sum2), .c_out(co2), .ovf(f2)
   );

   function automatic logic get_rdy(int sel);
      case (sel)
         0: return rdy0;
         1: return rdy1;
         default: return rdy2;
      endcase
   endfunction

   function automatic logic get_ov(int sel);
      case (sel)
         0: return ov0;
         1: return ov1;
         default: return ov2;
      endcase
   endfunction

   function automatic logic get_co(int sel);
      case (sel)
         0: return co0;
         1: return co1;
         default: return co2;
      endcase
   endfunction

   function automatic logic get_ovf(int sel);
      case (sel)
         0: return f0;
         1: return f1;
         default: return f2;
      endcase
   endfunction

   function automatic logic [15:0] get_sum(int sel);
      case (sel)
         0: return sum0;
         1: return {8'h00, sum1};
         default: return {8'h00, sum2};
      endcase
   endfunction

   // Reference model: plain integer arithmetic on unsigned and signed views.
   function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci, input logic is_sub,
                                 output logic [15:0] s, output logic co, output logic ov);
      longint modv, half, ua, ub, r, sa, sb, sr, cv;
      modv = longint'(1) << w;
      half = modv / 2;
      ua   = longint'(av) % modv;
      ub   = longint'(bv) % modv;
      cv   = ci ? 1 : 0;
      r    = is_sub ? (ua - ub - cv) : (ua + ub + cv);
      s    = 16'(r & (modv - 1));
      co   = is_sub ? (r >= 0) : (r >= modv);
      sa   = (ua >= half) ? ua - modv : ua;
      sb   = (ub >= half) ? ub - modv : ub;
      sr   = is_sub ? (sa - sb - cv) : (sa + sb + cv);
      ov   = (sr >= half) || (sr < -half);
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present operands at a falling edge, let the accept edge pass, scramble
   // the pins, then count edges until out_valid (bounded).
   task automatic start_and_wait(input int sel, input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci, input logic is_sub, output int lat);
      a = av; b = bv; c_in = ci; sub = is_sub;
      in_valid[sel] = 1'b1;
      @(negedge clk);
      in_valid[sel] = 1'b0;
      a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (get_ov(sel) !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finish_op(input int sel, input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " out_valid_after_ack"}, {15'd0, get_ov(sel)}, 16'd0);
      check({tag, " in_ready_after_ack"}, {15'd0, get_rdy(sel)}, 16'd1);
   endtask

   task automatic op(input int sel, input int w, input int exp_lat, input string tag,
                     input logic [15:0] av, input logic [15:0] bv,
                     input logic ci, input logic is_sub,
                     output logic [15:0] s_obs, output logic co_obs, output logic ov_obs);
      int          lat;
      logic [15:0] es;
      logic        eco, eov;
      check({tag, " in_ready"}, {15'd0, get_rdy(sel)}, 16'd1);
      start_and_wait(sel, av, bv, ci, is_sub, lat);
      check({tag, " latency"}, 16'(lat), 16'(exp_lat));
      model(w, av, bv, ci, is_sub, es, eco, eov);
      s_obs  = get_sum(sel);
      co_obs = get_co(sel);
      ov_obs = get_ovf(sel);
      check({tag, " sum"}, s_obs, es);
      check({tag, " c_out"}, {15'd0, co_obs}, {15'd0, eco});
      check({tag, " ovf"}, {15'd0, ov_obs}, {15'd0, eov});
      $display("op %s: a=%h b=%h cin=%0d sub=%0d -> sum=%h c_out=%0d ovf=%0d lat=%0d",
               tag, av, bv, ci, is_sub, s_obs, co_obs, ov_obs, lat);
      finish_op(sel, tag);
   endtask

   initial begin
      logic [15:0] s;
      logic        co, ov;
      logic [15:0] es;
      logic        eco, eov;
      int          lat;

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("reset in_ready", {15'd0, get_rdy(k)}, 16'd1);
         check("reset out_valid", {15'd0, get_ov(k)}, 16'd0);
         check("reset sum", get_sum(k), 16'd0);
         check("reset c_out", {15'd0, get_co(k)}, 16'd0);
         check("reset ovf", {15'd0, get_ovf(k)}, 16'd0);
      end
      @(negedge clk);

      // ---------------- directed 16/4 ----------------
      op(0, 16, 4, "add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 1'b0, s, co, ov);
      check("add_1234_0fff const", s, 16'h2233);
      check("add_1234_0fff cout const", {15'd0, co}, 16'd0);
      check("add_1234_0fff ovf const", {15'd0, ov}, 16'd0);

      op(0, 16, 4, "add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov);
      check("add_ffff_0001 const", s, 16'h0000);
      check("add_ffff_0001 cout const", {15'd0, co}, 16'd1);
      check("add_ffff_0001 ovf const", {15'd0, ov}, 16'd0);

      op(0, 16, 4, "add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov);
      check("add_7fff_0001 const", s, 16'h8000);
      check("add_7fff_0001 cout const", {15'd0, co}, 16'd0);
      check("add_7fff_0001 ovf const", {15'd0, ov}, 16'd1);

      op(0, 16, 4, "sub_0005_0007", 16'h0005, 16'h0007, 1'b0, 1'b1, s, co, ov);
      check("sub_0005_0007 const", s, 16'hFFFE);
      check("sub_0005_0007 cout const", {15'd0, co}, 16'd0);

      op(0, 16, 4, "sub_0009_0003_b", 16'h0009, 16'h0003, 1'b1, 1'b1, s, co, ov);
      check("sub_0009_0003_b const", s, 16'h0005);
      check("sub_0009_0003_b cout const", {15'd0, co}, 16'd1);
      check("sub_0009_0003_b ovf const", {15'd0, ov}, 16'd0);

      // ---------------- backpressure ----------------
      start_and_wait(0, 16'h4321, 16'h1111, 1'b1, 1'b0, lat);
      check("bp latency", 16'(lat), 16'd4);
      model(16, 16'h4321, 16'h1111, 1'b1, 1'b0, es, eco, eov);
      for (int i = 0; i < 5; i++) begin
         in_valid[0] = (i == 2);
         a = 16'($urandom);
         @(negedge clk);
         check("bp out_valid", {15'd0, ov0}, 16'd1);
         check("bp in_ready", {15'd0, rdy0}, 16'd0);
         check("bp sum", sum0, es);
         check("bp c_out", {15'd0, co0}, {15'd0, eco});
         check("bp ovf", {15'd0, f0}, {15'd0, eov});
      end
      in_valid[0] = 1'b0;
      $display("op bp_hold: a=4321 b=1111 cin=1 sub=0 -> sum=%h held 5 cycles", sum0);
      finish_op(0, "bp");

      // back-to-back operation straight after the result handshake
      op(0, 16, 4, "b2b_c000_8001", 16'hC000, 16'h8001, 1'b0, 1'b0, s, co, ov);
      check("b2b const", s, 16'h4001);

      // ---------------- reset mid-RUN ----------------
      a = 16'h1234; b = 16'h0FFF; c_in = 1'b0; sub = 1'b0;
      in_valid[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid out_valid", {15'd0, ov0}, 16'd0);
      check("rst_mid sum", sum0, 16'd0);
      check("rst_mid c_out", {15'd0, co0}, 16'd0);
      check("rst_mid ovf", {15'd0, f0}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_rel in_ready", {15'd0, rdy0}, 16'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rst_rel no_result", {15'd0, ov0}, 16'd0);
      end
      $display("op reset_mid_run: outputs cleared, in_ready=%0d", rdy0);
      op(0, 16, 4, "post_rst_1_1", 16'h0001, 16'h0001, 1'b0, 1'b0, s, co, ov);
      check("post_rst const", s, 16'h0002);

      // ---------------- random 8/8 and 8/1 ----------------
      for (int i = 0; i < 200; i++) begin
         op(1, 8, 1, "rnd_w8_d8", 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), s, co, ov);
      end
      for (int i = 0; i < 200; i++) begin
         op(2, 8, 8, "rnd_w8_d1", 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), s, co, ov);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised, multi-cycle adder/subtractor that generalises the fixed 4-bit ripple-carry adder.
- Adds WIDTH-bit operands DIGIT bits per clock, least-significant digit first, through one DIGIT-wide ripple stage plus a registered carry.
- Supports add and borrow-style subtract, reports carry and signed overflow.
- Has valid/ready handshakes on both sides so it can sit between datapath stages that use a shared narrow adder.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.
- N (derived, WIDTH/DIGIT), number of digit cycles per operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0 = A+B+c_in; 1 = A-B-c_in.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- c_out  out  1  add: carry out; sub: 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst_n low, async) forces IDLE, digit counter 0, carry register 0, sum/c_out/ovf/out_valid = 0. in_ready = (state==IDLE), so it reads 1 immediately after reset.
- IDLE: on in_valid && in_ready at a rising edge, capture a, b, sub into internal registers. Load the carry register with c_in XOR sub. Set counter to 0 and go to RUN.
- Operands on the a/b/c_in/sub pins are don't-care outside the accept edge; changes during RUN have no effect.
- Subtract: the effective B digit is ~B. Computes A + ~B + ~c_in = A - B - c_in.
- RUN, each edge: digit k = counter.
  - sum[k*DIGIT +: DIGIT] = Adig + Beff_dig + carry.
  - The carry register takes the digit carry-out.
  - The counter increments.
- On the edge with counter == N-1:
  - c_out = final carry.
  - ovf = carry into MSB XOR carry out of MSB.
  - out_valid = 1; go to DONE.
- Latency: out_valid rises exactly N clock edges after the accept edge (WIDTH=16, DIGIT=4 gives 4). With N=1, the result appears one edge after accept.
- DONE: sum, c_out, ovf and out_valid hold stable until out_valid && out_ready at an edge. Then out_valid = 0 and state returns to IDLE. sum/c_out/ovf keep their last value.
- in_ready is 0 in RUN and DONE; in_valid is ignored there. No overlap: the next accept occurs no earlier than the edge after the result handshake.
- out_ready asserted before out_valid has no effect.
- Reset asserted mid-RUN or mid-DONE: the operation is discarded, and all outputs and state return to reset values immediately. No partial result is ever presented.
- Counter width: clog2(N), minimum 1 bit. No wrap beyond N-1.

Test Plan:
- WIDTH=16, DIGIT=4: A=0x1234, B=0x0FFF, c_in=0, sub=0 → sum=0x2233, c_out=0, ovf=0. out_valid is high exactly 4 edges after accept.
- A=0xFFFF, B=0x0001, sub=0 → sum=0x0000, c_out=1, ovf=0. A=0x7FFF, B=0x0001 → sum=0x8000, c_out=0, ovf=1.
- sub=1: A=0x0005, B=0x0007, c_in=0 → sum=0xFFFE, c_out=0 (borrow). A=0x0009, B=0x0003, c_in=1 → sum=0x0005, c_out=1, ovf=0.
- Backpressure and pin isolation:
  - Hold out_ready=0 for 5 cycles in DONE: outputs stay stable, in_ready=0, a pulsed in_valid is not accepted.
  - Change a/b pins during RUN: result is unchanged.
  - Release out_ready: IDLE on the next edge, then back-to-back operation accepted.
- Drop rst_n mid-RUN (after digit 2) → all outputs 0, in_ready=1 after release. A new operation A=0x0001, B=0x0001 then gives 0x0002.
- Re-parametrise WIDTH=8, DIGIT=8 and WIDTH=8, DIGIT=1: random 200 operations in both modes match a reference model. Latency is 1 and 8 edges respectively.
